// File: rtl/dds_sweep_ctrl_if.sv
// Bus bundle between the sweep controller and its host: the configuration
// handshake, the abort request and the DDS-facing FreqPhase/Load/Enable lines.
`timescale 1ns/1ps

interface dds_sweep_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [DATA_WIDTH-1:0] cfg_phase;
    logic [DATA_WIDTH-1:0] cfg_freq_start;
    logic [DATA_WIDTH-1:0] cfg_freq_step;
    logic [CNT_WIDTH-1:0]  cfg_steps;
    logic [CNT_WIDTH-1:0]  cfg_dwell;
    logic                  abort;
    logic [DATA_WIDTH-1:0] FreqPhase;
    logic                  LoadP;
    logic                  LoadF;
    logic                  Enable;
    logic                  busy;
    logic                  done;

    // Host side: offers configurations, may abort, watches the DDS lines.
    modport master (
        output cfg_valid, cfg_phase, cfg_freq_start, cfg_freq_step,
               cfg_steps, cfg_dwell, abort,
        input  cfg_ready, FreqPhase, LoadP, LoadF, Enable, busy, done
    );

    // Controller side: accepts configurations and drives the DDS lines.
    modport slave (
        input  cfg_valid, cfg_phase, cfg_freq_start, cfg_freq_step,
               cfg_steps, cfg_dwell, abort,
        output cfg_ready, FreqPhase, LoadP, LoadF, Enable, busy, done
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep sequencer: loads the phase word once, then steps the frequency
// word linearly, generating the LoadP/LoadF pulses and the Enable level.
`timescale 1ns/1ps

module dds_sweep_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int PULSE_LEN  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input logic             clk,
    input logic             rst,
    dds_sweep_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, PH_SETUP, PH_HIGH, PH_LOW, FR_SETUP, FR_HIGH, FR_LOW, DWELL, DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] PULSE_LAST = CNT_WIDTH'(PULSE_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  steps_left_q, steps_left_d;
    logic [DATA_WIDTH-1:0] freq_cur_q, freq_cur_d;
    logic [DATA_WIDTH-1:0] step_q;
    logic [CNT_WIDTH-1:0]  dwell_q;
    logic [DATA_WIDTH-1:0] freq_phase_q;
    logic                  load_p_q, load_f_q, enable_q, busy_q, done_q;
    logic                  accept;
    logic                  step_decision;

    // Ready is the only combinational output; abort masks it so an abort
    // always wins over a configuration offered in the same cycle.
    assign bus.cfg_ready = (state_q == IDLE) && !bus.abort && !rst;

    assign bus.FreqPhase = freq_phase_q;
    assign bus.LoadP     = load_p_q;
    assign bus.LoadF     = load_f_q;
    assign bus.Enable    = enable_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // Next-state logic: per-state cycle counting and the zero-cycle step decision.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        cnt_d         = cnt_q;
        steps_left_d  = steps_left_q;
        freq_cur_d    = freq_cur_q;
        accept        = 1'b0;
        step_decision = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cfg_valid && bus.cfg_ready) begin
                    accept  = 1'b1;
                    state_d = PH_SETUP;
                end
            end
            PH_SETUP: begin
                state_d = PH_HIGH;
                cnt_d   = PULSE_LAST;
            end
            PH_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = PH_LOW;
                    cnt_d   = PULSE_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            PH_LOW: begin
                // freq_cur already holds the start frequency captured at accept.
                if (cnt_q == '0) state_d = FR_SETUP;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            FR_SETUP: begin
                state_d = FR_HIGH;
                cnt_d   = PULSE_LAST;
            end
            FR_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = FR_LOW;
                    cnt_d   = PULSE_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            FR_LOW: begin
                if (cnt_q == '0) begin
                    if (dwell_q != '0) begin
                        state_d = DWELL;
                        cnt_d   = dwell_q - CNT_ONE;
                    end else begin
                        step_decision = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DWELL: begin
                if (cnt_q == '0) step_decision = 1'b1;
                else             cnt_d         = cnt_q - CNT_ONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (step_decision) begin
            if (steps_left_q == '0) begin
                state_d = DONE;
            end else begin
                state_d      = FR_SETUP;
                freq_cur_d   = freq_cur_q + step_q;
                steps_left_d = steps_left_q - CNT_ONE;
            end
        end

        if (bus.abort) state_d = IDLE;
    end

    // Control state and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            steps_left_q <= '0;
            freq_cur_q   <= '0;
            freq_phase_q <= '0;
            load_p_q     <= 1'b0;
            load_f_q     <= 1'b0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            load_p_q <= (state_d == PH_HIGH);
            load_f_q <= (state_d == FR_HIGH);
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);

            if (accept) begin
                freq_cur_q   <= bus.cfg_freq_start;
                steps_left_q <= bus.cfg_steps;
                freq_phase_q <= bus.cfg_phase;
            end else begin
                freq_cur_q   <= freq_cur_d;
                steps_left_q <= steps_left_d;
                if (state_d == FR_SETUP) freq_phase_q <= freq_cur_d;
            end

            if (bus.abort)                enable_q <= 1'b0;
            else if (state_d == FR_HIGH)  enable_q <= 1'b1;
        end
    end

    // Configuration capture for step and dwell; only read after an accept.
    always_ff @(posedge clk) begin
        // NOTE: left out of reset on purpose; these are always written before use.
        if (accept) begin
            step_q  <= bus.cfg_freq_step;
            dwell_q <= bus.cfg_dwell;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed and randomized sweeps
// compared cycle by cycle against a timeline model derived from the sweep rules.
`timescale 1ns/1ps

module tb_dds_sweep_ctrl;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int P  = 2;

    typedef struct packed {
        logic [DW-1:0] phase;
        logic [DW-1:0] start;
        logic [DW-1:0] step;
        logic [CW-1:0] steps;
        logic [CW-1:0] dwell;
    } cfg_t;

    typedef struct packed {
        logic [DW-1:0] fp;
        logic          lp, lf, en, busy, done, rdy;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   en_model = 1'b0;

    always #5 clk = ~clk;

    dds_sweep_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    dds_sweep_ctrl #(.DATA_WIDTH(DW), .PULSE_LEN(P), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic obs_t observe();
        obs_t o;
        o.fp = bus.FreqPhase; o.lp = bus.LoadP; o.lf = bus.LoadF;
        o.en = bus.Enable; o.busy = bus.busy; o.done = bus.done; o.rdy = bus.cfg_ready;
        return o;
    endfunction

    function automatic int done_offset(cfg_t c);
        return 2 + 2*P + (int'(c.steps) + 1) * (1 + 2*P + int'(c.dwell));
    endfunction

    // Expected outputs k cycles after the accept cycle, from the sweep timeline:
    // phase block of 1+2P cycles, then N+1 frequency blocks of 1+2P+D, then DONE.
    function automatic obs_t model(cfg_t c, int k, bit en_prev);
        obs_t e;
        int f_len, first, dn, j, off;
        logic [31:0] fw;
        e     = '0;
        f_len = 1 + 2*P + int'(c.dwell);
        first = 2 + 2*P;
        dn    = done_offset(c);
        e.fp  = c.phase;
        if (k >= first) begin
            j = (k - first) / f_len;
            if (j > int'(c.steps)) j = int'(c.steps);
            fw   = 32'(c.start) + 32'(j) * 32'(c.step);
            e.fp = fw[DW-1:0];
        end
        off    = k - first;
        e.lp   = (k >= 2) && (k <= P + 1);
        e.lf   = (k >= first) && (k < dn) && ((off % f_len) >= 1) && ((off % f_len) <= P);
        e.en   = en_prev || (k >= first + 1);
        e.busy = (k >= 1) && (k <= dn);
        e.done = (k == dn);
        e.rdy  = (k > dn);
        return e;
    endfunction

    task automatic drive_cfg(input cfg_t c);
        bus.cfg_phase      = c.phase;
        bus.cfg_freq_start = c.start;
        bus.cfg_freq_step  = c.step;
        bus.cfg_steps      = c.steps;
        bus.cfg_dwell      = c.dwell;
        bus.cfg_valid      = 1'b1;
    endtask

    // Waits (bounded) for the handshake; returns at the negedge of cycle T+1.
    task automatic wait_accept(input string name, output int waited);
        bit ok = 1'b0;
        waited = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.cfg_ready === 1'b1) begin
                ok = 1'b1;
                waited = i;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s accept: cfg_ready never seen within 200 cycles", name);
        end else begin
            @(negedge clk);
        end
    endtask

    // Walks cycles 1..k_last after accept, comparing every output with the model.
    task automatic verify_sweep(input string name, input cfg_t c, input int k_last,
                                input bit hold_valid, input cfg_t next_c);
        bit   en_prev = en_model;
        obs_t exp_o, got_o;
        if (hold_valid) drive_cfg(next_c);
        else            bus.cfg_valid = 1'b0;
        for (int k = 1; k <= k_last; k++) begin
            exp_o = model(c, k, en_prev);
            got_o = observe();
            checks++;
            if (got_o !== exp_o) begin
                errors++;
                $display("FAIL %s cycle T+%0d got fp=%h lp=%b lf=%b en=%b busy=%b done=%b rdy=%b expected fp=%h lp=%b lf=%b en=%b busy=%b done=%b rdy=%b",
                         name, k, got_o.fp, got_o.lp, got_o.lf, got_o.en, got_o.busy, got_o.done, got_o.rdy,
                         exp_o.fp, exp_o.lp, exp_o.lf, exp_o.en, exp_o.busy, exp_o.done, exp_o.rdy);
            end
            if (k < k_last) @(negedge clk);
        end
        if (k_last >= 3 + 2*P) en_model = 1'b1;
    endtask

    task automatic run_full(input string name, input cfg_t c);
        int w;
        drive_cfg(c);
        wait_accept(name, w);
        if (w >= 0) verify_sweep(name, c, done_offset(c) + 1, 1'b0, c);
    endtask

    task automatic test_reset();
        obs_t got_o;
        rst = 1'b1;
        drive_cfg('{16'h1234, 16'h0001, 16'h0001, 16'd1, 16'd1});
        repeat (3) begin
            @(negedge clk);
            got_o = observe();
            checks++;
            if (got_o !== '0) begin
                errors++;
                $display("FAIL reset_hold got %h expected all zero", got_o);
            end
        end
        rst = 1'b0;
        bus.cfg_valid = 1'b0;
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b expected 1", bus.cfg_ready);
        end
        @(negedge clk);
        got_o = observe();
        checks++;
        if (got_o !== obs_t'({{DW{1'b0}}, 6'b000001})) begin
            errors++;
            $display("FAIL reset_idle got %h expected only rdy set", got_o);
        end
        en_model = 1'b0;
    endtask

    task automatic test_basic();
        run_full("basic", '{16'h4000, 16'h0100, 16'h0100, 16'd2, 16'd3});
    endtask

    task automatic test_wrap();
        run_full("wrap_up", '{16'h0A0A, 16'hFFF0, 16'h0010, 16'd2, 16'd0});
        run_full("neg_step", '{16'h0001, 16'h0005, 16'hFFFE, 16'd2, 16'd1});
    endtask

    task automatic test_zero_steps();
        run_full("zero_steps", '{16'h7777, 16'hBEEF, 16'h1111, 16'd0, 16'd0});
    endtask

    task automatic test_abort();
        cfg_t c = '{16'h2222, 16'h0300, 16'h0040, 16'd3, 16'd2};
        obs_t got_o, exp_o;
        int   w;
        drive_cfg(c);
        wait_accept("abort", w);
        if (w < 0) return;
        verify_sweep("abort_pre", c, 3 + 2*P, 1'b0, c);   // first LoadF cycle
        bus.abort = 1'b1;
        drive_cfg('{16'h5555, 16'h6666, 16'h0001, 16'd1, 16'd0});
        @(negedge clk);
        exp_o = '0;
        exp_o.fp = c.start;
        got_o = observe();
        checks++;
        if (got_o !== exp_o) begin
            errors++;
            $display("FAIL abort_next got %h expected %h", got_o, exp_o);
        end
        @(negedge clk);
        got_o = observe();
        checks++;
        if (got_o !== exp_o) begin
            errors++;
            $display("FAIL abort_priority got %h expected %h", got_o, exp_o);
        end
        bus.abort = 1'b0;
        bus.cfg_valid = 1'b0;
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_release_ready got %b expected 1", bus.cfg_ready);
        end
        en_model = 1'b0;
    endtask

    task automatic test_back_to_back();
        cfg_t c1 = '{16'h1000, 16'h0020, 16'h0003, 16'd1, 16'd1};
        cfg_t c2 = '{16'h3000, 16'hF000, 16'h8001, 16'd2, 16'd0};
        int   w;
        drive_cfg(c1);
        wait_accept("b2b_first", w);
        if (w < 0) return;
        verify_sweep("b2b_first", c1, done_offset(c1) + 1, 1'b1, c2);
        wait_accept("b2b_second", w);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL b2b_gap waited %0d cycles expected 0", w);
        end
        if (w >= 0) verify_sweep("b2b_second", c2, done_offset(c2) + 1, 1'b0, c2);
    endtask

    task automatic test_random();
        cfg_t c;
        for (int i = 0; i < 6; i++) begin
            c.phase = DW'($urandom);
            c.start = DW'($urandom);
            c.step  = DW'($urandom);
            c.steps = CW'($urandom_range(0, 3));
            c.dwell = CW'($urandom_range(0, 4));
            run_full($sformatf("random%0d", i), c);
        end
    endtask

    task automatic test_reset_mid();
        cfg_t c = '{16'h0F0F, 16'h0404, 16'h0101, 16'd2, 16'd1};
        obs_t got_o;
        int   w;
        drive_cfg(c);
        wait_accept("reset_mid", w);
        if (w < 0) return;
        verify_sweep("reset_mid_pre", c, 4 + 2*P, 1'b0, c);
        rst = 1'b1;
        @(negedge clk);
        got_o = observe();
        checks++;
        if (got_o !== '0) begin
            errors++;
            $display("FAIL reset_mid got %h expected all zero", got_o);
        end
        rst = 1'b0;
        @(negedge clk);
        got_o = observe();
        checks++;
        if (got_o !== obs_t'({{DW{1'b0}}, 6'b000001})) begin
            errors++;
            $display("FAIL reset_mid_after got %h expected only rdy set", got_o);
        end
        en_model = 1'b0;
    endtask

    initial begin
        bus.abort = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_steps();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencing controller for the DDS stage. It drives the DDS shared FreqPhase bus and its LoadP, LoadF and Enable inputs. It accepts one sweep configuration over a valid/ready handshake: phase, start frequency, signed step, step count and dwell time. It then loads the phase once and steps the frequency word linearly, producing each load pulse (rising and falling edge) the DDS requires.

Parameters:
DATA_WIDTH, 16, width of the FreqPhase bus and of the phase/frequency/step words
PULSE_LEN, 2, cycles each Load pulse is high; also the minimum low time after it (>=1)
CNT_WIDTH, 16, width of the step-count and dwell counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  controller accepts configuration
cfg_phase  in  DATA_WIDTH  phase word to load
cfg_freq_start  in  DATA_WIDTH  first frequency word
cfg_freq_step  in  DATA_WIDTH  signed two's-complement frequency increment
cfg_steps  in  CNT_WIDTH  number of increments N (N+1 frequencies loaded)
cfg_dwell  in  CNT_WIDTH  extra cycles held after each frequency load
abort  in  1  terminate sweep immediately
FreqPhase  out  DATA_WIDTH  DDS data bus
LoadP  out  1  DDS phase load pulse
LoadF  out  1  DDS frequency load pulse
Enable  out  1  DDS enable
busy  out  1  sweep in progress (state != IDLE)
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset: state IDLE; FreqPhase=0, LoadP=0, LoadF=0, Enable=0, busy=0, done=0. cfg_ready=1 from the first cycle after reset is released.
- All outputs are registered except cfg_ready = (state==IDLE) && !abort.
- Accept: cfg_valid && cfg_ready in cycle T. All cfg_* values are latched in T. cfg_* values are ignored at all other times.
- States: IDLE, PH_SETUP, PH_HIGH, PH_LOW, FR_SETUP, FR_HIGH, FR_LOW, DWELL, DONE.
- PH_SETUP (1 cycle, T+1): FreqPhase=phase; LoadP=0.
- PH_HIGH (PULSE_LEN cycles): LoadP=1; FreqPhase held.
- PH_LOW (PULSE_LEN cycles): LoadP=0; FreqPhase held.
- FR_SETUP (1 cycle): FreqPhase=freq_cur. On entry from PH_LOW, freq_cur=cfg_freq_start.
- FR_HIGH (PULSE_LEN cycles): LoadF=1. Enable set to 1 in the first FR_HIGH cycle and kept at 1 afterwards.
- FR_LOW (PULSE_LEN cycles): LoadF=0; FreqPhase held.
- DWELL (cfg_dwell cycles): FreqPhase held. dwell=0 skips this state with no extra cycle.
- Step decision, zero cycles, at the end of FR_LOW/DWELL:
  - steps_left==0 -> DONE.
  - Otherwise -> FR_SETUP with freq_cur += step (modulo 2^DATA_WIDTH, wrap silently) and steps_left -= 1.
- DONE (1 cycle): done=1. Next state IDLE.
- Enable remains 1 after DONE, so the last tone keeps playing. A new configuration does not clear Enable. Only abort or rst clears it.
- LoadP and LoadF are never high in the same cycle. FreqPhase changes only in SETUP states.
- Cycle count per sweep: 1+2P for the phase, (1+2P+D) per frequency, then 1 cycle for DONE.
- abort, in any state including IDLE: next cycle state=IDLE, LoadP=0, LoadF=0, Enable=0, done=0. FreqPhase keeps its last value.
- abort has priority over cfg_valid in the same cycle; the configuration is not accepted.
- rst mid-sweep: identical to the reset values above. No done pulse.
- cfg_steps=0: exactly one frequency load, then DONE.

Test Plan:
- Reset/idle: assert rst for 3 cycles with cfg_valid=1 -> all outputs 0, nothing accepted. After release, cfg_ready=1.
- Basic sweep, P=2: phase=0x4000, start=0x0100, step=0x0100, N=2, dwell=3, accepted at T:
  - LoadP=1 at T+2..T+3 with FreqPhase=0x4000.
  - LoadF=1 at T+7..8, T+15..16, T+23..24 with FreqPhase=0x0100, 0x0200, 0x0300.
  - Enable=1 from T+7.
  - done=1 at T+30; cfg_ready=1 at T+31.
- Wrap/negative step:
  - start=0xFFF0, step=0x0010, N=2, dwell=0 -> frequency sequence 0xFFF0, 0x0000, 0x0010.
  - start=0x0005, step=0xFFFE -> frequency sequence 0x0005, 0x0003, 0x0001.
- N=0, dwell=0: exactly one LoadF pulse; done occurs 1+2P cycles after the phase block ends.
- Abort during FR_HIGH (LoadF=1) -> next cycle LoadF=0, Enable=0, busy=0, no done. Abort with cfg_valid in the same cycle -> cfg_ready=0 and no accept.
- Back-to-back: second cfg_valid held high through the first sweep -> accepted in the first IDLE cycle after DONE. Enable stays 1 throughout the gap.
